// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/exec/wb control FSM (imem req/ack in, rf read/write addresses and ALU opcode out, owns pc, busy/halted status and retired count)
module alu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [17:0]      imem_rdata,
  output logic [4:0]       rf_raddr0,
  output logic [4:0]       rf_raddr1,
  output logic [2:0]       alu_opcode,
  input  logic             alu_change_pc,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t state, state_d;
  logic [PC_W-1:0] pc_d, off, pc_inc;
  logic [CNT_W-1:0] ret_d, ret_inc;
  logic [17:0] instr, instr_d;
  logic [2:0] op;
  logic [4:0] rd, rs0, rs1;
  logic rd_phase, op_phase;
  assign op = instr[17:15];
  assign rd = instr[14:10];
  assign rs0 = instr[9:5];
  assign rs1 = instr[4:0];
  assign off = PC_W'($signed(rd));
  assign pc_inc = pc + PC_W'(1);
  assign ret_inc = retired + CNT_W'(1);
  assign rd_phase = (state == DECODE) || (state == EXEC) || (state == WB);
  assign op_phase = (state == EXEC) || (state == WB);
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign rf_raddr0 = rd_phase ? rs0 : 5'd0;
  assign rf_raddr1 = rd_phase ? rs1 : 5'd0;
  assign alu_opcode = op_phase ? op : 3'd0;
  assign rf_we = state == WB;
  assign rf_waddr = rf_we ? rd : 5'd0;
  assign busy = rd_phase || (state == FETCH);
  assign halted = state == HALT;
  always_comb begin
    state_d = state;
    pc_d = pc;
    ret_d = retired;
    instr_d = instr;
    case (state)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: begin
        instr_d = imem_ack ? imem_rdata : instr;
        state_d = imem_ack ? DECODE : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = op[2] ? WB : (op == 3'd1 ? HALT : FETCH);
        ret_d = op[2] ? retired : ret_inc;
        pc_d = (op[2] || op == 3'd1) ? pc : ((op[1] && alu_change_pc) ? pc + off : pc_inc);
      end
      WB: begin
        state_d = FETCH;
        pc_d = pc_inc;
        ret_d = ret_inc;
      end
      default: state_d = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      retired <= '0;
      instr <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      retired <= ret_d;
      instr <= instr_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a combinational program memory
module tb_alu_sequencer;
  logic clk = 0, rst = 1, start = 0, imem_ack, alu_change_pc = 0, ack_v = 1;
  logic imem_req, rf_we, busy, halted;
  logic [7:0] imem_addr, pc;
  logic [17:0] imem_rdata;
  logic [4:0] rf_raddr0, rf_raddr1, rf_waddr;
  logic [2:0] alu_opcode;
  logic [15:0] retired;
  logic [17:0] mem [256];
  int n_chk = 0, n_fail = 0;
  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1),
    .alu_opcode(alu_opcode), .alu_change_pc(alu_change_pc), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .pc(pc), .busy(busy), .halted(halted), .retired(retired)
  );
  always #5 clk = ~clk;
  assign imem_ack = ack_v;
  assign imem_rdata = mem[imem_addr];
  function automatic logic [17:0] enc(input int op, input int rd, input int rs0, input int rs1);
    return {op[2:0], rd[4:0], rs0[4:0], rs1[4:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1;
    step(1);
    start = 0;
  endtask
  task automatic wait_pc(input logic [7:0] t);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1);
      hit = imem_req && pc == t;
    end
    chk("wait_pc", {imem_req, pc}, {1'b1, t});
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_we"}, rf_we, 0);
    chk({tag, "_op"}, alu_opcode, 0);
    chk({tag, "_ra"}, {rf_raddr0, rf_raddr1, rf_waddr}, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_ret"}, retired, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = enc(0, 5, 0, 0);
    mem[0] = enc(4, 3, 1, 2);
    mem[1] = enc(0, 5, 7, 9);
    mem[5] = enc(2, -3, 0, 0);
    mem[6] = enc(3, -7, 0, 0);
    mem[255] = enc(3, 2, 0, 0);
    step(2);
    chk_idle("reset");
    rst = 0;
    step(1);
    pulse_start();
    chk("f_req", imem_req, 1);
    chk("f_addr", imem_addr, 0);
    chk("f_busy", busy, 1);
    step(1);
    chk("d_raddr", {rf_raddr0, rf_raddr1}, {5'd1, 5'd2});
    chk("d_req", imem_req, 0);
    chk("d_we", rf_we, 0);
    step(1);
    chk("e_op", alu_opcode, 4);
    chk("e_we", rf_we, 0);
    alu_change_pc = 1;
    step(1);
    chk("wb_we", rf_we, 1);
    chk("wb_waddr", rf_waddr, 3);
    chk("wb_op", alu_opcode, 4);
    ack_v = 0;
    step(1);
    chk("add_pc", pc, 1);
    chk("add_ret", retired, 1);
    chk("add_we_off", rf_we, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 1);
      chk("stall_we", rf_we, 0);
      step(1);
    end
    ack_v = 1;
    step(1);
    chk("stall_dec_req", imem_req, 0);
    chk("stall_dec_ra", {rf_raddr0, rf_raddr1}, {5'd7, 5'd9});
    step(1);
    chk("nop_op", alu_opcode, 0);
    step(1);
    chk("nop_pc", pc, 2);
    chk("nop_ret", retired, 2);
    wait_pc(5);
    step(2);
    chk("beq_op", alu_opcode, 2);
    chk("beq_we", rf_we, 0);
    step(1);
    chk("beq_t_pc", {imem_req, pc}, {1'b1, 8'd2});
    chk("beq_t_ret", retired, 6);
    wait_pc(5);
    alu_change_pc = 0;
    step(2);
    chk("beq_n_we", rf_we, 0);
    step(1);
    chk("beq_n_pc", {imem_req, pc}, {1'b1, 8'd6});
    chk("beq_n_ret", retired, 10);
    alu_change_pc = 1;
    step(3);
    chk("blt_wrap_back", pc, 255);
    step(3);
    chk("blt_wrap_fwd", pc, 1);
    chk("blt_ret", retired, 12);
    mem[1] = enc(3, -2, 0, 0);
    step(3);
    chk("blt_back2", pc, 255);
    mem[255] = enc(0, 5, 0, 0);
    step(3);
    chk("nop_wrap", pc, 0);
    chk("nop_wrap_ret", retired, 14);
    mem[0] = enc(2, 7, 0, 0);
    step(3);
    chk("beq_fwd", pc, 7);
    mem[7] = enc(1, 0, 0, 0);
    step(3);
    chk("halt_flag", {halted, busy, imem_req}, 3'b100);
    chk("halt_pc", pc, 7);
    chk("halt_ret", retired, 16);
    pulse_start();
    step(2);
    chk("halt_sticky", {halted, busy, imem_req}, 3'b100);
    chk("halt_sticky_pc", pc, 7);
    chk("halt_sticky_ret", retired, 16);
    rst = 1;
    step(1);
    chk_idle("halt_rst");
    rst = 0;
    mem[0] = enc(4, 3, 1, 2);
    step(1);
    pulse_start();
    step(3);
    chk("rstwb_we", rf_we, 1);
    rst = 1;
    step(1);
    chk_idle("rst_wb");
    rst = 0;
    ack_v = 0;
    step(1);
    pulse_start();
    step(2);
    chk("rstf_req", imem_req, 1);
    rst = 1;
    step(1);
    chk_idle("rst_fetch");
    rst = 0;
    ack_v = 1;
    step(3);
    chk_idle("late_ack");
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
